dog_subtract: RTL and testbench

DOG_SUBTRACT -- requirements
Module: dog_subtract

---
 rtl/dog_subtract.sv | 147 ++++++++++++++
 tb/tb_dog_subtract.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dog_subtract.sv
// Difference-of-Gaussians subtractor.
// Streams every pixel address of a DIMENSION x DIMENSION image to two Gaussian
// BRAMs that share one address bus, subtracts the less-blurred pixel from the
// more-blurred one, and writes the signed difference to a DoG BRAM. The
// address travels through a pipeline matched to the BRAM read latency, so
// each write carries the address of the pixel it was computed from.
module dog_subtract #(
  parameter int BIT_DEPTH    = 8,
  parameter int DIMENSION    = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_in,
  input  logic                                     start,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0]   read_address,
  input  logic [BIT_DEPTH-1:0]                     blur_hi_data,
  input  logic [BIT_DEPTH-1:0]                     blur_lo_data,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0]   write_address,
  output logic signed [BIT_DEPTH:0]                write_data,
  output logic                                     write_valid,
  output logic                                     busy,
  output logic                                     done
);

  localparam int             NPIX = DIMENSION * DIMENSION;
  localparam int             AW   = $clog2(NPIX);
  localparam logic [AW-1:0]  LAST = AW'(NPIX - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        read_address_q, read_address_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 armed_q;
  logic                 issue_valid;

  logic                 pipe_valid_q [READ_LATENCY];
  logic [AW-1:0]        pipe_addr_q  [READ_LATENCY];

  logic                 write_valid_q;
  logic [AW-1:0]        write_address_q;
  logic [BIT_DEPTH:0]   write_data_q;
  logic [BIT_DEPTH:0]   diff;

  // Zero-extend both pixels so the subtraction wraps into a signed
  // BIT_DEPTH+1-bit result that can never overflow.
  assign diff = {1'b0, blur_hi_data} - {1'b0, blur_lo_data};

  // Next-state logic for the sequencer: issue addresses, drain, pulse done.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d        = state_q;
    read_address_d = read_address_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    issue_valid    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && armed_q) begin
          read_address_d = '0;
          busy_d         = 1'b1;
          state_d        = S_STREAM;
        end
      end
      S_STREAM: begin
        issue_valid = 1'b1;
        if (read_address_q == LAST) state_d = S_DRAIN;
        else                        read_address_d = read_address_q + 1'b1;
      end
      S_DRAIN: begin
        if (write_valid_q && (write_address_q == LAST)) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state; armed_q blocks a start on the first edge after reset.
  always_ff @(posedge clk or negedge rst_in) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst_in) begin
      state_q        <= S_IDLE;
      read_address_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_address_q <= read_address_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      armed_q        <= 1'b1;
    end
  end

  // Valid bits of the latency-matching pipeline; cleared on reset so an
  // aborted image issues no stray writes.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_valid_q[i] <= 1'b0;
    end else begin
      pipe_valid_q[0] <= issue_valid;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid_q[i] <= pipe_valid_q[i-1];
    end
  end

  // Address payload of the pipeline, qualified by the valid bits above.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; it is only ever consumed under its
    // valid bit, and leaving it unreset keeps it a plain shift register.
    pipe_addr_q[0] <= read_address_q;
    for (int i = 1; i < READ_LATENCY; i++) pipe_addr_q[i] <= pipe_addr_q[i-1];
  end

  // Output register: write strobe every cycle, address/data held between writes.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      write_valid_q   <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
    end else begin
      write_valid_q <= pipe_valid_q[READ_LATENCY-1];
      if (pipe_valid_q[READ_LATENCY-1]) begin
        write_address_q <= pipe_addr_q[READ_LATENCY-1];
        write_data_q    <= diff;
      end
    end
  end

  assign read_address  = read_address_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign write_valid   = write_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_dog_subtract.sv
// Directed bench for dog_subtract: two instances (read latency 2 and 3) fed
// by behavioural Gaussian BRAM models sharing one pixel table.
module tb_dog_subtract;

  logic       clk;
  logic       rst_in;
  logic       start2, start3;
  logic [3:0] ra2, ra3, wa2, wa3;
  logic [7:0] hi2, lo2, hi3, lo3;
  logic [8:0] wd2, wd3;
  logic       wv2, wv3, busy2, busy3, done2, done3;

  logic [7:0] hi_mem [16];
  logic [7:0] lo_mem [16];
  logic [3:0] a2_q [2];
  logic [3:0] a3_q [3];
  logic [8:0] cap2 [16];
  logic [8:0] cap3 [16];

  int n_checks = 0;
  int n_errors = 0;

  dog_subtract #(.BIT_DEPTH(8), .DIMENSION(4), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_in(rst_in), .start(start2), .read_address(ra2),
    .blur_hi_data(hi2), .blur_lo_data(lo2), .write_address(wa2),
    .write_data(wd2), .write_valid(wv2), .busy(busy2), .done(done2)
  );

  dog_subtract #(.BIT_DEPTH(8), .DIMENSION(4), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_in(rst_in), .start(start3), .read_address(ra3),
    .blur_hi_data(hi3), .blur_lo_data(lo3), .write_address(wa3),
    .write_data(wd3), .write_valid(wv3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: address registered, then READ_LATENCY-1 further stages.
  always @(posedge clk) begin
    a2_q[0] <= ra2;
    a2_q[1] <= a2_q[0];
    a3_q[0] <= ra3;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  assign hi2 = hi_mem[a2_q[1]];
  assign lo2 = lo_mem[a2_q[1]];
  assign hi3 = hi_mem[a3_q[2]];
  assign lo3 = lo_mem[a3_q[2]];

  function automatic logic [8:0] exp_diff(input int a);
    return {1'b0, hi_mem[a]} - {1'b0, lo_mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string who, input logic [3:0] ra, input logic [3:0] wa,
                            input logic [8:0] wd, input logic wv, input logic bz, input logic dn);
    check({who, "_rst_raddr"}, 32'(ra), 0);
    check({who, "_rst_waddr"}, 32'(wa), 0);
    check({who, "_rst_wdata"}, 32'(wd), 0);
    check({who, "_rst_valid"}, 32'(wv), 0);
    check({who, "_rst_busy"},  32'(bz), 0);
    check({who, "_rst_done"},  32'(dn), 0);
  endtask

  // Expected outputs c cycles after the start edge for read latency lat.
  task automatic check_cycle(input string who, input int c, input int lat, input bit en,
                             input logic [3:0] ra, input logic [3:0] wa, input logic [8:0] wd,
                             input logic wv, input logic bz, input logic dn);
    int  first, last;
    bit  exp_wv;
    first = lat + 1;
    last  = lat + 16;
    if (!en) begin
      check({who, "_idle_valid"}, 32'(wv), 0);
      check({who, "_idle_busy"},  32'(bz), 0);
      check({who, "_idle_done"},  32'(dn), 0);
    end else begin
      exp_wv = (c >= first) && (c <= last);
      check({who, "_valid"}, 32'(wv), 32'(exp_wv));
      if (exp_wv) begin
        check({who, "_waddr"}, 32'(wa), 32'(c - first));
        check({who, "_wdata"}, 32'(wd), 32'(exp_diff(c - first)));
      end else if (c > last) begin
        check({who, "_hold_waddr"}, 32'(wa), 15);
        check({who, "_hold_wdata"}, 32'(wd), 32'(exp_diff(15)));
      end
      check({who, "_done"}, 32'(dn), 32'(c == last + 2));
      check({who, "_busy"}, 32'(bz), 32'(c < last + 2));
      if (c <= last + 1) check({who, "_raddr"}, 32'(ra), (c < 15) ? c : 15);
    end
  endtask

  // One image: edge 0 is the accepted start (already taken when prestarted).
  task automatic do_run(input bit en2, input bit en3, input bit prestarted,
                        input bit pulses, input bit chain);
    int wr2, wr3, dn2, dn3;
    wr2 = 0; wr3 = 0; dn2 = 0; dn3 = 0;
    for (int a = 0; a < 16; a++) begin
      cap2[a] = 9'h1AA;
      cap3[a] = 9'h1AA;
    end
    if (!prestarted) begin
      start2 = en2;
      start3 = en3;
      @(posedge clk);
      @(negedge clk);
    end
    start2 = 1'b0;
    start3 = 1'b0;
    if (en2) begin
      check("d2_start_raddr", 32'(ra2), 0);
      check("d2_start_busy", 32'(busy2), 1);
    end
    if (en3) check("d3_start_busy", 32'(busy3), 1);
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!(chain && c == 21)) begin
        check_cycle("d2", c, 2, en2, ra2, wa2, wd2, wv2, busy2, done2);
        if (wv2) begin wr2++; cap2[wa2] = wd2; end
        if (done2) dn2++;
      end
      check_cycle("d3", c, 3, en3, ra3, wa3, wd3, wv3, busy3, done3);
      if (wv3) begin wr3++; cap3[wa3] = wd3; end
      if (done3) dn3++;
      if (pulses && (c == 4 || c == 17)) begin
        start2 = en2;
        start3 = en3;
      end else begin
        start2 = chain && (c == 20);
        start3 = 1'b0;
      end
    end
    check("d2_write_count", 32'(wr2), en2 ? 16 : 0);
    check("d2_done_count",  32'(dn2), 32'(en2));
    check("d3_write_count", 32'(wr3), en3 ? 16 : 0);
    check("d3_done_count",  32'(dn3), 32'(en3));
  endtask

  initial begin
    rst_in = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    for (int a = 0; a < 16; a++) begin
      hi_mem[a] = 8'(10 * a);
      lo_mem[a] = 8'(5 * a);
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("d2", ra2, wa2, wd2, wv2, busy2, done2);
    check_zero("d3", ra3, wa3, wd3, wv3, busy3, done3);

    // Start coinciding with the first edge after release is not acted on.
    rst_in = 1'b1;
    start2 = 1'b1;
    start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("d2_first_edge_busy", 32'(busy2), 0);
    check("d3_first_edge_busy", 32'(busy3), 0);

    // Basic run: hi=10A, lo=5A on both latencies.
    do_run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("d2_basic_a15", 32'(cap2[15]), 32'd75);
    check("d2_basic_a6",  32'(cap2[6]),  32'd30);
    check("d3_basic_a15", 32'(cap3[15]), 32'd75);

    // Sign extremes and equal inputs; start pulses inside the run are ignored;
    // a start right after done chains a second run on the latency-2 instance.
    hi_mem[3] = 8'd0;   lo_mem[3] = 8'd255;
    hi_mem[4] = 8'd255; lo_mem[4] = 8'd0;
    hi_mem[7] = 8'd77;  lo_mem[7] = 8'd77;
    do_run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("d2_neg255", 32'(cap2[3]), 32'h101);
    check("d2_pos255", 32'(cap2[4]), 32'h0FF);
    check("d2_equal",  32'(cap2[7]), 32'h000);
    check("d3_neg255", 32'(cap3[3]), 32'h101);
    check("d3_pos255", 32'(cap3[4]), 32'h0FF);
    do_run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("d2_chain_neg255", 32'(cap2[3]), 32'h101);
    check("d2_chain_pos255", 32'(cap2[4]), 32'h0FF);

    // Reset mid-run right after the write to address 6.
    start2 = 1'b1;
    start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    start3 = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("d2_pre_abort_valid", 32'(wv2), 1);
    check("d2_pre_abort_waddr", 32'(wa2), 6);
    rst_in = 1'b0;
    #1;
    check_zero("d2_abort", ra2, wa2, wd2, wv2, busy2, done2);
    check_zero("d3_abort", ra3, wa3, wd3, wv3, busy3, done3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_in = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("d2_post_abort_valid", 32'(wv2), 0);
      check("d3_post_abort_valid", 32'(wv3), 0);
      check("d2_post_abort_busy",  32'(busy2), 0);
    end

    // Fresh start after the abort covers all addresses again.
    do_run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("d2_restart_a0",  32'(cap2[0]),  32'd0);
    check("d2_restart_a15", 32'(cap2[15]), 32'd75);
    check("d3_restart_a3",  32'(cap3[3]),  32'h101);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
